i2c_slave_regwrite: RTL



---
 rtl/i2c_slave_regwrite.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regwrite.sv
// Write-only I2C target. Oversamples SCL/SDA on clk, detects START/STOP,
// matches a 7-bit device address, takes a register-pointer byte and then
// turns every following data byte into a one-cycle register-file write
// strobe with an auto-incrementing address.
module i2c_slave_regwrite #(
  parameter logic [6:0] DEV_ADDR    = 7'h0A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       xfer_done
);

  typedef enum logic [2:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_p_q, sda_p_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] ptr_q, ptr_d;
  logic       ack_on_q, ack_on_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       xfer_done_q, xfer_done_d;
  logic [7:0] byte_in;

  // Input synchronizers plus one delayed copy for edge detection; idle-high bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p_q;
  assign scl_fall  = ~scl_s & scl_p_q;
  // While we pull SDA low for an ACK, SDA edges are our own and not bus conditions.
  assign start_det = sda_p_q & ~sda_s & scl_s & scl_p_q & ~sda_oe_q;
  assign stop_det  = ~sda_p_q & sda_s & scl_s & scl_p_q & ~sda_oe_q;
  assign byte_in   = {sr_q[6:0], sda_s};

  // State and output registers; reset aborts any transfer without writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd7;
      sr_q        <= 8'h00;
      ptr_q       <= 8'h00;
      ack_on_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      ack_on_q    <= ack_on_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit/ACK handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ptr_d       = ptr_q;
    ack_on_d    = ack_on_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    xfer_done_d = 1'b0;

    // Pointer advances the cycle after each strobe, wrapping naturally at 8 bits.
    if (wr_en_q) ptr_d = ptr_q + 8'd1;

    if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      ack_on_d    = 1'b0;
      busy_d      = 1'b0;
      xfer_done_d = busy_q;
    end else if (start_det) begin
      state_d  = DEV;
      cnt_d    = 3'd7;
      sda_oe_d = 1'b0;
      ack_on_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        DEV, REG, DATA: begin
          if (scl_rise) begin
            sr_d = byte_in;
            if (cnt_q != 3'd0) begin
              cnt_d = cnt_q - 3'd1;
            end else if (state_q == DEV) begin
              if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                busy_d  = 1'b1;
                state_d = DEV_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == REG) begin
              ptr_d   = byte_in;
              state_d = REG_ACK;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              state_d   = DATA_ACK;
            end
          end
        end
        DEV_ACK, REG_ACK, DATA_ACK: begin
          // First SCL fall starts the ACK bit, the second one ends it.
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              cnt_d    = 3'd7;
              state_d  = (state_q == DEV_ACK) ? REG : DATA;
            end
          end
        end
        IDLE, IGNORE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign xfer_done = xfer_done_q;

endmodule
